// File: rtl/branch_predictor.sv
// Fetch-stage direct-mapped branch predictor: 2-bit counters plus a tagged BTB, trained from EX.
// Optional BP_STATS_EN adds lookup and mispredict statistics counters.
module branch_predictor #(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  output logic        pcsrc,
  output logic [31:0] pred_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred,
  input  logic [31:0] resolve_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0] stat_lookups,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];

  logic [IDX_BITS-1:0] fetch_idx, res_idx;
  logic [TAG_BITS-1:0] fetch_tag, res_tag;
  logic                fetch_hit, res_hit, mis_cond;

  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag = fetch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  assign res_idx   = resolve_pc[IDX_BITS+1:2];
  assign res_tag   = resolve_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];

  // Lookup reads the registered table only, so a same-cycle update is seen one cycle later.
  always_comb begin
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    pcsrc       = fetch_valid && fetch_hit && ctr_q[fetch_idx][1];
    pred_target = pcsrc ? target_q[fetch_idx] : '0;
  end

  always_comb begin
    res_hit  = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    mis_cond = resolve_valid &&
               ((resolve_pred != resolve_taken) ||
                (resolve_taken && resolve_pred && (resolve_pred_target != resolve_target)));
  end

  // NOTE: the table is built from flops, not a RAM macro, because every entry must clear on
  // the asynchronous reset; a RAM could not be reset in a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
    end else if (resolve_valid) begin
      if (res_hit) begin
        if (resolve_taken) begin
          if (ctr_q[res_idx] != 2'b11) ctr_q[res_idx] <= ctr_q[res_idx] + 2'd1;
          target_q[res_idx] <= resolve_target;
        end else if (ctr_q[res_idx] != 2'b00) begin
          ctr_q[res_idx] <= ctr_q[res_idx] - 2'd1;
        end
      end else if (resolve_taken) begin
        // Allocate weakly taken; a not-taken miss leaves the entry alone.
        valid_q[res_idx]  <= 1'b1;
        tag_q[res_idx]    <= res_tag;
        ctr_q[res_idx]    <= 2'b10;
        target_q[res_idx] <= resolve_target;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mis_cond;
      if (resolve_valid) redirect_pc <= resolve_taken ? resolve_target : resolve_pc + 32'd4;
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (fetch_valid) stat_lookups     <= stat_lookups + 32'd1;
      if (mis_cond)    stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: training, saturation, aliasing,
// same-cycle lookup/update ordering and mispredict/redirect generation.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pcsrc;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred;
  logic [31:0] resolve_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lookups = 0;
  int exp_mis     = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fetch_valid         (fetch_valid),
    .fetch_pc            (fetch_pc),
    .pcsrc               (pcsrc),
    .pred_target         (pred_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred        (resolve_pred),
    .resolve_pred_target (resolve_pred_target),
    .mispredict          (mispredict),
    .redirect_pc         (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_lookups        (stat_lookups),
    .stat_mispredicts    (stat_mispredicts)
`endif
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    if (fetch_valid) exp_lookups++;
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                         input logic pred, input logic [31:0] ptarget);
    resolve_valid       = 1'b1;
    resolve_pc          = pc;
    resolve_taken       = taken;
    resolve_target      = target;
    resolve_pred        = pred;
    resolve_pred_target = ptarget;
  endtask

  task automatic idle();
    resolve_valid = 1'b0;
  endtask

  task automatic clk_mp(input string name, input logic exp_mp, input logic [31:0] exp_redir);
    tick();
    check({name, "_mispredict"}, {31'd0, mispredict}, {31'd0, exp_mp});
    check({name, "_redirect"}, redirect_pc, exp_redir);
    if (exp_mp) exp_mis++;
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic exp_src,
                      input logic [31:0] exp_tgt);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    #1;
    check({name, "_pcsrc"}, {31'd0, pcsrc}, {31'd0, exp_src});
    check({name, "_target"}, pred_target, exp_tgt);
  endtask

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b1;
    fetch_pc = 32'h100;
    resolve_valid = 1'b0;
    resolve_pc = '0;
    resolve_taken = 1'b0;
    resolve_target = '0;
    resolve_pred = 1'b0;
    resolve_pred_target = '0;

    #3;
    check("rst_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("rst_target", pred_target, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_redirect", redirect_pc, 32'd0);
    #9 rst_n = 1'b1;
    look("post_reset", 32'h100, 1'b0, 32'h0);

    // First taken resolve allocates weakly taken and flags the not-taken prediction.
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    look("alloc_same_cycle", 32'h100, 1'b0, 32'h0);
    clk_mp("alloc", 1'b1, 32'h200);
    idle();
    look("alloc_lookup", 32'h100, 1'b1, 32'h200);

    for (int i = 0; i < 3; i++) begin
      resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      clk_mp("taken_sat", 1'b0, 32'h200);
      idle();
      look("taken_sat_lookup", 32'h100, 1'b1, 32'h200);
    end

    // Counter at 11: taken stays predicted only through the first not-taken resolve.
    for (int i = 0; i < 4; i++) begin
      resolve(32'h100, 1'b0, 32'h200, (i == 0), 32'h200);
      clk_mp("nt", (i == 0), 32'h104);
      idle();
      look("nt_lookup", 32'h100, (i == 0), (i == 0) ? 32'h200 : 32'h0);
    end

    // From 00 it takes two taken resolves to predict taken again.
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    clk_mp("floor_up1", 1'b1, 32'h200);
    idle();
    look("floor_up1_lookup", 32'h100, 1'b0, 32'h0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    clk_mp("floor_up2", 1'b1, 32'h200);
    idle();
    look("floor_up2_lookup", 32'h100, 1'b1, 32'h200);
    resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
    clk_mp("train", 1'b0, 32'h200);

    // Alias on the same index replaces the entry.
    resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
    clk_mp("alias", 1'b1, 32'h300);
    idle();
    look("alias_old", 32'h100, 1'b0, 32'h0);
    look("alias_new", 32'h200, 1'b1, 32'h300);
    clk_mp("idle_hold", 1'b0, 32'h300);

    // Not-taken tag miss must leave the aliased entry's counter untouched.
    resolve(32'h100, 1'b0, 32'h999, 1'b0, 32'h0);
    clk_mp("nt_miss", 1'b0, 32'h104);
    idle();
    look("nt_miss_lookup", 32'h200, 1'b1, 32'h300);

    // Bring 0x100 back at counter 01, then check same-cycle lookup/update ordering.
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    clk_mp("realloc", 1'b1, 32'h200);
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    clk_mp("weaken", 1'b1, 32'h104);
    idle();
    look("weak_lookup", 32'h100, 1'b0, 32'h0);
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    look("same_cycle", 32'h100, 1'b0, 32'h0);
    clk_mp("same_cycle_upd", 1'b1, 32'h200);
    idle();
    look("next_cycle", 32'h100, 1'b1, 32'h200);

    // Right direction, wrong target.
    resolve(32'h100, 1'b1, 32'h240, 1'b1, 32'h200);
    clk_mp("bad_target", 1'b1, 32'h240);
    idle();
    look("new_target", 32'h100, 1'b1, 32'h240);
    fetch_valid = 1'b0;
    #1;
    check("fetch_off_pcsrc", {31'd0, pcsrc}, 32'd0);
    check("fetch_off_target", pred_target, 32'd0);

`ifdef BP_STATS_EN
    check("stat_lookups", stat_lookups, exp_lookups);
    check("stat_mispredicts", stat_mispredicts, exp_mis);
`endif

    // Reset with an update in flight: table clears and the update is dropped.
    resolve(32'h100, 1'b1, 32'h500, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_mispredict", {31'd0, mispredict}, 32'd0);
    check("midrst_redirect", redirect_pc, 32'd0);
    look("midrst_lookup", 32'h100, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    idle();
    rst_n = 1'b1;
    look("after_midrst", 32'h100, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-stage dynamic branch predictor, directly upstream of the hazard/flush logic.
- Supplies the predicted branch direction (pcsrc) and the predicted target to the IF stage. The hazard unit compares pcsrc against the resolved outcome (branchreal) to raise ifflush.
- Implements a direct-mapped table: one 2-bit saturating counter plus one tagged BTB entry per index.
- The table is trained from the EX-stage branch resolution port.

Parameters:
- IDX_BITS, 6, log2 of table entries (64 entries).
- TAG_BITS, 8, number of PC tag bits stored per entry.

Ports:
- clk  input  1  pipeline clock
- rst_n  input  1  asynchronous active-low reset
- fetch_valid  input  1  IF stage is presenting a PC this cycle
- fetch_pc  input  32  IF-stage PC
- pcsrc  output  1  predicted taken for fetch_pc
- pred_target  output  32  predicted target; 0 when pcsrc=0
- resolve_valid  input  1  EX stage resolved a conditional branch this cycle
- resolve_pc  input  32  PC of the resolved branch
- resolve_taken  input  1  actual direction (branchreal)
- resolve_target  input  32  actual taken target
- resolve_pred  input  1  pcsrc value that travelled down the pipe with this branch
- resolve_pred_target  input  32  pred_target that travelled with this branch
- mispredict  output  1  registered mispredict flag for the resolved branch
- redirect_pc  output  32  correct next PC, valid when mispredict=1

Behaviour:
- Field extraction, applied to both fetch_pc and resolve_pc:
  - idx = pc[IDX_BITS+1:2]
  - tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]
  - pc[1:0] is ignored.
- Each entry holds: valid (1), tag (TAG_BITS), ctr (2), target (32).
- Lookup is combinational, zero latency:
  - hit = valid[idx] && tag match
  - pcsrc = fetch_valid && hit && ctr[1]
  - pred_target = target[idx] when pcsrc, else 0
- Update happens on the clk rising edge when resolve_valid=1:
  - Tag hit, taken: ctr saturates upward (00 -> 01 -> 10 -> 11, holds at 11); target is rewritten with resolve_target.
  - Tag hit, not taken: ctr saturates downward (11 -> 10 -> 01 -> 00, holds at 00); target is unchanged.
  - Tag miss or invalid entry, taken: allocate the entry. Set valid=1, tag=resolve tag, ctr=10 (weakly taken), target=resolve_target.
  - Tag miss or invalid entry, not taken: no table change.
- Mispredict logic, registered one cycle after resolve_valid:
  - mispredict = resolve_valid && ((resolve_pred != resolve_taken) || (resolve_taken && resolve_pred && resolve_pred_target != resolve_target))
  - redirect_pc = resolve_taken ? resolve_target : resolve_pc + 4 (32-bit wrap)
  - When resolve_valid=0, mispredict=0 on the next cycle and redirect_pc holds its value.
- Lookup and update to the same idx in the same cycle: lookup returns the pre-update entry. There is no bypass; the new state is visible from the next cycle.
- Reset, asynchronous, active while rst_n=0:
  - All valid=0, all ctr=01, all tag=0, all target=0.
  - mispredict=0, redirect_pc=0.
  - Therefore pcsrc=0 and pred_target=0 while reset is asserted and immediately after it.
- Reset asserted mid-update: the table is cleared and the in-flight update is lost.
- fetch_valid=0 forces pcsrc=0 but does not affect updates.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_lookups[31:0] and stat_mispredicts[31:0].
  - stat_lookups increments on every cycle with fetch_valid=1.
  - stat_mispredicts increments on every cycle with resolve_valid=1 whose computed mispredict condition is true (same cycle the flag is registered).
  - Both counters wrap at 2^32 and reset to 0 on rst_n=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then fetch_pc=0x00000100 with fetch_valid=1 -> pcsrc=0, pred_target=0.
- Resolve pc=0x100 taken, target 0x200, resolve_pred=0 -> next cycle mispredict=1, redirect_pc=0x200. Subsequent lookup of 0x100 -> pcsrc=1, pred_target=0x200 (ctr=10).
- Three more taken resolves of 0x100, then four not-taken resolves:
  - ctr saturates at 11 after the taken resolves.
  - pcsrc stays 1 through the first not-taken resolve, then 0 from the second onward.
  - ctr ends at 00.
- Alias: pc 0x100 is trained taken; then pc 0x100+(1<<(IDX_BITS+2)) resolves taken to 0x300 -> entry replaced, lookup of 0x100 gives pcsrc=0. A not-taken resolve on a tag miss -> table unchanged.
- Same-cycle lookup and update of 0x100 (ctr 01 -> 10) -> same-cycle pcsrc=0, next cycle pcsrc=1.
- Predicted taken to 0x200, resolved taken to 0x240 -> mispredict=1, redirect_pc=0x240. With BP_STATS_EN defined, stat_mispredicts increments by 1.
